// File: rtl/trap_pkg.sv
// trap_pkg: shared cause codes, PC-source encodings and FSM states for trap_ctrl.
package trap_pkg;
  typedef enum logic [1:0] {ST_RESET, ST_OPERATING, ST_TRAP_TAKEN, ST_TRAP_RETURN} state_e;
  localparam logic [1:0] PC_BOOT = 2'b00;
  localparam logic [1:0] PC_MEPC = 2'b01;
  localparam logic [1:0] PC_TRAP = 2'b10;
  localparam logic [1:0] PC_NEXT = 2'b11;
  localparam logic [31:0] CAUSE_MISALIGNED_INSTR = 32'd0;
  localparam logic [31:0] CAUSE_ILLEGAL          = 32'd2;
  localparam logic [31:0] CAUSE_EBREAK           = 32'd3;
  localparam logic [31:0] CAUSE_ECALL            = 32'd11;
  localparam logic [31:0] CAUSE_MISALIGNED_LOAD  = 32'd4;
  localparam logic [31:0] CAUSE_MISALIGNED_STORE = 32'd6;
  localparam logic [31:0] CAUSE_EXT_IRQ          = 32'h8000_000B;
  localparam logic [31:0] CAUSE_SW_IRQ           = 32'h8000_0003;
  localparam logic [31:0] CAUSE_TIMER_IRQ        = 32'h8000_0007;
endpackage

// File: rtl/sync_ff.sv
// sync_ff: reset-clearable multi-stage synchronizer for an asynchronous level.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);
  logic [STAGES-1:0] r_sync;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_sync <= '0;
    else r_sync <= {r_sync[STAGES-2:0], i_d};
  assign o_q = r_sync[STAGES-1];
endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap sequencer driving mstatus/mepc/mcause strobes,
// PC-source select and pipeline flush from exceptions, interrupts and mret.
module trap_ctrl
  import trap_pkg::*;
#(
  parameter int IRQ_SYNC_STAGES = 2
) (
  input  logic        clock,
  input  logic        rst_n_in,
  input  logic [31:0] pc_in,
  input  logic        misaligned_instr_in,
  input  logic        illegal_instr_in,
  input  logic        ecall_in,
  input  logic        ebreak_in,
  input  logic        misaligned_load_in,
  input  logic        misaligned_store_in,
  input  logic        mret_in,
  input  logic        e_irq_in,
  input  logic        t_irq_in,
  input  logic        s_irq_in,
  input  logic        mie_in,
  input  logic        meie_in,
  input  logic        mtie_in,
  input  logic        msie_in,
  output logic        mie_clear_out,
  output logic        mie_set_out,
  output logic        mepc_wr_out,
  output logic [31:0] mepc_out,
  output logic        mcause_wr_out,
  output logic [31:0] mcause_out,
  output logic [1:0]  pc_src_out,
  output logic        flush_out,
  output logic        trap_taken_out
);
  state_e      r_state;
  logic        w_e_sync;
  logic        w_exc;
  logic        w_irq;
  logic [31:0] w_cause;

  sync_ff #(.STAGES(IRQ_SYNC_STAGES)) u_sync (
    .i_clk  (clock),
    .i_rst_n(rst_n_in),
    .i_d    (e_irq_in),
    .o_q    (w_e_sync)
  );

  assign w_exc = misaligned_instr_in | illegal_instr_in | ecall_in | ebreak_in |
                 misaligned_load_in | misaligned_store_in;
  assign w_irq = mie_in & ((w_e_sync & meie_in) | (s_irq_in & msie_in) | (t_irq_in & mtie_in));

  always_comb
    w_cause = misaligned_instr_in ? CAUSE_MISALIGNED_INSTR :
              illegal_instr_in    ? CAUSE_ILLEGAL :
              ebreak_in           ? CAUSE_EBREAK :
              ecall_in            ? CAUSE_ECALL :
              misaligned_load_in  ? CAUSE_MISALIGNED_LOAD :
              misaligned_store_in ? CAUSE_MISALIGNED_STORE :
              (w_e_sync & meie_in) ? CAUSE_EXT_IRQ :
              (s_irq_in & msie_in) ? CAUSE_SW_IRQ : CAUSE_TIMER_IRQ;

  // Outputs are registered alongside the next state, so they track the state register.
  always_ff @(posedge clock or negedge rst_n_in)
    if (!rst_n_in) begin
      r_state        <= ST_RESET;
      mie_clear_out  <= 1'b0;
      mie_set_out    <= 1'b0;
      mepc_wr_out    <= 1'b0;
      mcause_wr_out  <= 1'b0;
      flush_out      <= 1'b0;
      trap_taken_out <= 1'b0;
      pc_src_out     <= PC_BOOT;
      mepc_out       <= '0;
      mcause_out     <= '0;
    end else begin
      mie_clear_out  <= 1'b0;
      mie_set_out    <= 1'b0;
      mepc_wr_out    <= 1'b0;
      mcause_wr_out  <= 1'b0;
      flush_out      <= 1'b0;
      trap_taken_out <= 1'b0;
      pc_src_out     <= PC_NEXT;
      r_state        <= ST_OPERATING;
      if (r_state == ST_OPERATING) begin
        if (w_exc | w_irq) begin
          r_state        <= ST_TRAP_TAKEN;
          mie_clear_out  <= 1'b1;
          mepc_wr_out    <= 1'b1;
          mcause_wr_out  <= 1'b1;
          flush_out      <= 1'b1;
          trap_taken_out <= 1'b1;
          pc_src_out     <= PC_TRAP;
          mepc_out       <= pc_in;
          mcause_out     <= w_cause;
        end else if (mret_in) begin
          r_state     <= ST_TRAP_RETURN;
          mie_set_out <= 1'b1;
          flush_out   <= 1'b1;
          pc_src_out  <= PC_MEPC;
        end
      end
    end
endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed and randomized checks of trap_ctrl against a cycle-level
// model of what each cycle must emit, given the previous cycle's decision.
module tb_trap_ctrl;
  localparam int STAGES = 2;
  localparam int K_BOOT = 0, K_RUN = 1, K_TRAP = 2, K_RET = 3;
  localparam logic [31:0] CODES [9] = '{32'd0, 32'd2, 32'd3, 32'd11, 32'd4, 32'd6,
                                        32'h8000000B, 32'h80000003, 32'h80000007};

  logic        clock = 0;
  logic        rst_n_in = 1;
  logic [31:0] pc_in = 0;
  logic        misaligned_instr_in = 0, illegal_instr_in = 0, ecall_in = 0, ebreak_in = 0;
  logic        misaligned_load_in = 0, misaligned_store_in = 0, mret_in = 0;
  logic        e_irq_in = 0, t_irq_in = 0, s_irq_in = 0;
  logic        mie_in = 0, meie_in = 0, mtie_in = 0, msie_in = 0;
  logic        mie_clear_out, mie_set_out, mepc_wr_out, mcause_wr_out, flush_out, trap_taken_out;
  logic [31:0] mepc_out, mcause_out;
  logic [1:0]  pc_src_out;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 0;

  int          m_kind = K_BOOT;
  logic [31:0] m_mepc = 0, m_mcause = 0;
  logic [STAGES-1:0] m_ehist = '0;

  trap_ctrl #(.IRQ_SYNC_STAGES(STAGES)) dut (
    .clock(clock), .rst_n_in(rst_n_in), .pc_in(pc_in),
    .misaligned_instr_in(misaligned_instr_in), .illegal_instr_in(illegal_instr_in),
    .ecall_in(ecall_in), .ebreak_in(ebreak_in),
    .misaligned_load_in(misaligned_load_in), .misaligned_store_in(misaligned_store_in),
    .mret_in(mret_in), .e_irq_in(e_irq_in), .t_irq_in(t_irq_in), .s_irq_in(s_irq_in),
    .mie_in(mie_in), .meie_in(meie_in), .mtie_in(mtie_in), .msie_in(msie_in),
    .mie_clear_out(mie_clear_out), .mie_set_out(mie_set_out),
    .mepc_wr_out(mepc_wr_out), .mepc_out(mepc_out),
    .mcause_wr_out(mcause_wr_out), .mcause_out(mcause_out),
    .pc_src_out(pc_src_out), .flush_out(flush_out), .trap_taken_out(trap_taken_out)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [32:0] pick_cause(input logic [8:0] c);
    for (int i = 0; i < 9; i++)
      if (c[i]) return {1'b1, CODES[i]};
    return 33'd0;
  endfunction

  // External irq is seen STAGES cycles late; a trap or return cycle ignores inputs.
  always @(posedge clock or negedge rst_n_in)
    if (!rst_n_in) begin
      m_kind   <= K_BOOT;
      m_mepc   <= 0;
      m_mcause <= 0;
      m_ehist  <= '0;
    end else begin
      logic [32:0] pc;
      pc = pick_cause({mie_in & t_irq_in & mtie_in, mie_in & s_irq_in & msie_in,
                       mie_in & m_ehist[STAGES-1] & meie_in, misaligned_store_in,
                       misaligned_load_in, ecall_in, ebreak_in, illegal_instr_in,
                       misaligned_instr_in});
      m_ehist <= {m_ehist[STAGES-2:0], e_irq_in};
      if (m_kind != K_RUN) m_kind <= K_RUN;
      else if (pc[32]) begin
        m_kind   <= K_TRAP;
        m_mepc   <= pc_in;
        m_mcause <= pc[31:0];
      end else if (mret_in) m_kind <= K_RET;
      else m_kind <= K_RUN;
    end

  always @(negedge clock)
    if (cmp_en) begin
      logic [5:0] ectl;
      logic [1:0] epc;
      ectl = (m_kind == K_TRAP) ? 6'b101111 : (m_kind == K_RET) ? 6'b010010 : 6'b000000;
      epc  = (m_kind == K_BOOT) ? 2'b00 : (m_kind == K_RUN) ? 2'b11 :
             (m_kind == K_TRAP) ? 2'b10 : 2'b01;
      chk("model_ctrl", {26'd0, mie_clear_out, mie_set_out, mepc_wr_out, mcause_wr_out,
                         flush_out, trap_taken_out}, {26'd0, ectl});
      chk("model_pc_src", {30'd0, pc_src_out}, {30'd0, epc});
      chk("model_mepc", mepc_out, m_mepc);
      chk("model_mcause", mcause_out, m_mcause);
    end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_in();
    {misaligned_instr_in, illegal_instr_in, ecall_in, ebreak_in} = 0;
    {misaligned_load_in, misaligned_store_in, mret_in} = 0;
    {e_irq_in, t_irq_in, s_irq_in, mie_in, meie_in, mtie_in, msie_in} = 0;
  endtask

  initial begin
    #1 rst_n_in = 0;
    #1 cmp_en = 1;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_outputs", {mie_clear_out, mie_set_out, mepc_wr_out, mcause_wr_out, flush_out,
                        trap_taken_out, pc_src_out}, 0);
    chk("rst_mcause", mcause_out, 0);
    rst_n_in = 1;
    chk("boot_pc_src", pc_src_out, 2'b00);
    step();
    chk("run_pc_src", pc_src_out, 2'b11);
    chk("run_mcause", mcause_out, 0);

    illegal_instr_in = 1; pc_in = 32'h40;
    step();
    clear_in();
    chk("ill_strobes", {mie_clear_out, mepc_wr_out, mcause_wr_out, flush_out, trap_taken_out}, 5'b11111);
    chk("ill_pc_src", pc_src_out, 2'b10);
    chk("ill_mepc", mepc_out, 32'h40);
    chk("ill_mcause", mcause_out, 2);
    step();
    chk("ill_after_pc_src", pc_src_out, 2'b11);
    chk("ill_after_strobe", mie_clear_out, 0);

    ecall_in = 1; misaligned_load_in = 1; t_irq_in = 1; mtie_in = 1; mie_in = 1;
    step();
    clear_in();
    chk("prio_mcause", mcause_out, 11);
    step();

    e_irq_in = 1; meie_in = 1; mie_in = 1;
    step(); chk("ext_lat1", trap_taken_out, 0);
    step(); chk("ext_lat2", trap_taken_out, 0);
    step(); chk("ext_lat3", trap_taken_out, 1);
    chk("ext_mcause", mcause_out, 32'h8000000B);
    e_irq_in = 0; mie_in = 0;
    repeat (3) step();
    e_irq_in = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("ext_masked", trap_taken_out, 0);
    end
    clear_in();
    repeat (3) step();

    mret_in = 1;
    step();
    clear_in();
    chk("mret_ctl", {mie_set_out, flush_out, mepc_wr_out, mcause_wr_out, mie_clear_out}, 5'b11000);
    chk("mret_pc_src", pc_src_out, 2'b01);
    step();
    mret_in = 1; illegal_instr_in = 1;
    step();
    clear_in();
    chk("mret_ill_trap", trap_taken_out, 1);
    chk("mret_ill_noset", mie_set_out, 0);
    step();

    illegal_instr_in = 1; pc_in = 32'h1234;
    step();
    chk("midrst_trap", trap_taken_out, 1);
    rst_n_in = 0;
    #1;
    chk("midrst_async", {mie_clear_out, mie_set_out, mepc_wr_out, mcause_wr_out, flush_out,
                         trap_taken_out, pc_src_out}, 0);
    chk("midrst_mepc", mepc_out, 0);
    clear_in();
    step();
    chk("midrst_held", {mie_clear_out, pc_src_out}, 0);
    rst_n_in = 1;
    step();
    chk("midrst_run", {mie_clear_out, pc_src_out}, 3'b011);
    step();
    chk("midrst_noclr", mie_clear_out, 0);

    for (int n = 0; n < 3000; n++) begin
      step();
      rst_n_in            = ($urandom_range(0, 199) != 0);
      pc_in               = $urandom;
      misaligned_instr_in = ($urandom_range(0, 15) == 0);
      illegal_instr_in    = ($urandom_range(0, 15) == 0);
      ecall_in            = ($urandom_range(0, 15) == 0);
      ebreak_in           = ($urandom_range(0, 15) == 0);
      misaligned_load_in  = ($urandom_range(0, 15) == 0);
      misaligned_store_in = ($urandom_range(0, 15) == 0);
      mret_in             = ($urandom_range(0, 5) == 0);
      e_irq_in            = ($urandom_range(0, 2) == 0);
      t_irq_in            = ($urandom_range(0, 2) == 0);
      s_irq_in            = ($urandom_range(0, 2) == 0);
      mie_in              = $urandom_range(0, 1) != 0;
      meie_in             = $urandom_range(0, 1) != 0;
      mtie_in             = $urandom_range(0, 1) != 0;
      msie_in             = $urandom_range(0, 1) != 0;
    end
    rst_n_in = 1;
    clear_in();
    repeat (4) step();
    cmp_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Machine-mode trap sequencer. Sits directly upstream of the mstatus register block.
- Each cycle it examines synchronous exceptions, enabled pending interrupts and mret, then runs a small FSM.
- Per trap it emits one-cycle strobes: mie_clear, mie_set, mepc/mcause writes, PC-source select and pipeline flush.
- It also produces the mcause and mepc write data.

Parameters:
- IRQ_SYNC_STAGES, 2, flip-flop stages on the asynchronous external interrupt input (legal 2..3).

Ports:
- clock  in  1  system clock
- rst_n_in  in  1  asynchronous reset, active low
- pc_in  in  32  PC of the instruction in the trap-check stage
- misaligned_instr_in  in  1  instruction address misaligned
- illegal_instr_in  in  1  illegal instruction
- ecall_in  in  1  ecall decoded
- ebreak_in  in  1  ebreak decoded
- misaligned_load_in  in  1  load address misaligned
- misaligned_store_in  in  1  store address misaligned
- mret_in  in  1  mret decoded
- e_irq_in  in  1  external interrupt, asynchronous level
- t_irq_in  in  1  timer interrupt, synchronous level
- s_irq_in  in  1  software interrupt, synchronous level
- mie_in  in  1  mstatus.MIE
- meie_in  in  1  mie.MEIE
- mtie_in  in  1  mie.MTIE
- msie_in  in  1  mie.MSIE
- mie_clear_out  out  1  trap entry strobe to mstatus
- mie_set_out  out  1  mret strobe to mstatus
- mepc_wr_out  out  1  mepc write strobe
- mepc_out  out  32  mepc write data
- mcause_wr_out  out  1  mcause write strobe
- mcause_out  out  32  mcause write data; bit31 = interrupt, [3:0] = code
- pc_src_out  out  2  00 boot, 01 mepc, 10 trap vector, 11 next PC
- flush_out  out  1  flush fetch/decode
- trap_taken_out  out  1  trap entry indicator

Behaviour:
- Reset (rst_n_in low, asynchronous):
  - State = RESET.
  - All strobes, flush_out and trap_taken_out = 0.
  - mcause_out = 0, mepc_out = 0, pc_src_out = 00.
  - Synchronizer flops cleared.
  - Reset asserted mid-trap aborts immediately; no partial strobes are emitted afterwards.
- External interrupt: e_irq_in passes through IRQ_SYNC_STAGES flops before use. t_irq_in and s_irq_in are used directly.
- Exception present = OR of the six exception inputs.
- Interrupt pending = mie_in & ((e_sync & meie_in) | (s_irq_in & msie_in) | (t_irq_in & mtie_in)).
- FSM states: RESET, OPERATING, TRAP_TAKEN, TRAP_RETURN.
  - RESET: pc_src_out = 00; next state OPERATING unconditionally.
  - OPERATING: pc_src_out = 11.
    - Exception or interrupt pending -> TRAP_TAKEN.
    - Else mret_in -> TRAP_RETURN.
    - Else stay.
    - Trap beats mret when both occur.
  - TRAP_TAKEN, one cycle: mie_clear_out = mepc_wr_out = mcause_wr_out = flush_out = trap_taken_out = 1; pc_src_out = 10; next state OPERATING.
  - TRAP_RETURN, one cycle: mie_set_out = flush_out = 1; pc_src_out = 01; next state OPERATING.
- All control outputs are Moore, decoded from the registered state. Latency is one cycle from input condition to strobe.
- On the OPERATING->TRAP_TAKEN edge, mepc_out <= pc_in and mcause_out is registered. Both hold until the next trap entry.
- Cause priority, highest first:
  - misaligned_instr 0
  - illegal 2
  - ebreak 3
  - ecall 11
  - misaligned_load 4
  - misaligned_store 6
  - external irq 0x8000000B
  - software irq 0x80000003
  - timer irq 0x80000007
- Any exception beats any interrupt.
- Inputs are ignored while in TRAP_TAKEN or TRAP_RETURN, because the instruction is flushed. A condition still held in the following OPERATING cycle re-evaluates normally.
- Interrupt pending with mie_in = 0 causes no trap.
- A timer level that is still high right after entry does not re-trap, because mstatus MIE is clear after mie_clear.

Decomposition:
- Shared package trap_pkg:
  - Cause-code constants.
  - PC_SRC encodings 00/01/10/11.
  - FSM state encoding.
- One natural sub-module: sync_ff, a parameterised IRQ_SYNC_STAGES reset-clearable synchronizer.
- Cause priority encoder stays inline.

Test Plan:
- Reset release: rst_n_in low for 3 cycles, then high -> pc_src_out = 00 for 1 cycle, then 11. All strobes stay 0 and mcause_out = 0.
- Illegal instruction: illegal_instr_in = 1 with pc_in = 0x00000040 -> next cycle mie_clear_out = mepc_wr_out = mcause_wr_out = flush_out = 1, pc_src_out = 10, mepc_out = 0x40, mcause_out = 2. The cycle after returns to pc_src_out = 11.
- Priority: ecall_in and misaligned_load_in together with t_irq_in, mtie_in and mie_in all 1 -> mcause_out = 11.
- External interrupt latency: e_irq_in rises with meie_in = mie_in = 1 and IRQ_SYNC_STAGES = 2 -> TRAP_TAKEN strobes appear 3 cycles later, mcause_out = 0x8000000B. Same stimulus with mie_in = 0 -> no trap.
- mret: mret_in = 1 -> next cycle mie_set_out = 1, flush_out = 1, pc_src_out = 01, no mepc or mcause write. mret_in together with illegal_instr_in -> TRAP_TAKEN, and no mie_set_out.
- Reset mid-trap: assert rst_n_in low in the same cycle as TRAP_TAKEN -> all outputs drop to 0 asynchronously, state returns to RESET, and no mie_clear_out is seen afterwards.
